mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for the shared combinational multiply-accumulate datapath (az + mx*my, WIDTH-bit operands, 2*WIDTH-bit accumulate).
- Runs a dot product of programmable length: accepts a config command, streams operand pairs through the datapath one per accepted beat, keeps the running sum in its own accumulator register, and returns the final sum on a result handshake.
- Sits between the command/operand source and the mac datapath instance, which it drives exclusively.

Parameters:
- WIDTH, 16, operand width of mx/my.
- LEN_W, 8, width of the term-count field; max dot-product length 2^LEN_W-1.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- cfg_start  input  1  start command; sampled only in IDLE.
- cfg_len  input  LEN_W  number of terms, latched on accepted start.
- cfg_acc_init  input  2*WIDTH  initial accumulator value, latched on accepted start.
- cfg_abort  input  1  abandon the current operation.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  operand pair accepted this cycle when in_valid && in_ready.
- in_x  input  WIDTH  multiplicand.
- in_y  input  WIDTH  multiplier.
- mac_mx  output  WIDTH  to datapath mx.
- mac_my  output  WIDTH  to datapath my.
- mac_az  output  2*WIDTH  to datapath az.
- mac_res  input  2*WIDTH  datapath result: az + mx*my, combinational.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed when res_valid && res_ready.
- res_data  output  2*WIDTH  final accumulator value.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, acc=0, cnt=0, len_q=0; busy=0, in_ready=0, res_valid=0, res_data=0, mac_mx=0, mac_my=0, mac_az=0.
- States: IDLE, RUN, DONE, encoded as 2-bit constants.
- IDLE:
  - On cfg_start && !cfg_abort: len_q<=cfg_len, acc<=cfg_acc_init, cnt<=0.
  - Next state is RUN if cfg_len!=0, otherwise DONE, where res_data=cfg_acc_init one cycle later.
- RUN:
  - in_ready=1. mac_mx=in_x, mac_my=in_y, mac_az=acc (combinational pass-through).
  - On accept: acc<=mac_res, cnt<=cnt+1.
  - If cnt+1==len_q, go to DONE on the same edge.
  - No accept means hold everything.
- DONE:
  - res_valid=1, res_data=acc.
  - On res_ready: go to IDLE. acc is retained until the next start.
- Outside RUN: in_ready=0, mac_mx=0, mac_my=0, mac_az=acc.
- Throughput and latency:
  - One term per cycle under continuous in_valid.
  - Result valid on the cycle after the last accept. Total latency is len+1 cycles from start, excluding stalls.
- Arithmetic: unsigned, modulo 2^(2*WIDTH). Accumulator wrap is silent; there is no overflow flag.
- cfg_start outside IDLE: ignored, with no side effects.
- cfg_abort, any state: next state IDLE, acc<=0, cnt<=0, no result produced.
  - Abort wins over a same-cycle accept: acc is not updated.
  - Abort wins over a same-cycle res_ready and over a same-cycle start in IDLE.
- res_valid stays asserted with res_data stable until the handshake completes or an abort occurs.
- Reset mid-RUN or mid-DONE: immediate return to the reset values. A partial sum is never output.
- Outputs in_ready, busy and res_valid are decoded from the state register only, with no combinational path from inputs.

Decomposition:
- Shared include/package: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), default WIDTH and LEN_W.
- No sub-module required. The term counter and accumulator are inline.
- The datapath is instantiated by the parent and wired to the mac_* ports. The bench instantiates it as well, for end-to-end checking.

Test Plan:
- Basic dot product: start len=3, init=0; pairs (2,3),(4,5),(6,7) with continuous valid -> res_valid on the cycle after the 3rd accept, res_data=68, busy low after res_ready.
- Wrap: len=1, init=0x0001FFFF, pair (0xFFFF,0xFFFF) -> res_data=0x00000000 (0x0001FFFF+0xFFFE0001 mod 2^32).
- Zero length: start len=0, init=0x12345678 -> no in_ready pulse, res_valid one cycle later with res_data=0x12345678.
- Stalls and backpressure: len=2, init=10, in_valid toggled 1/0 with pairs (1,1),(3,3); res_ready held low for 5 cycles -> res_data=20 stable and res_valid held; start pulses during RUN/DONE ignored.
- Abort: len=4, abort asserted together with the 2nd in_valid -> that beat not accumulated, IDLE next cycle, no res_valid. A new start len=1 init=0 pair (5,5) then gives 25.
- Async reset: drop RST_N mid-RUN between clock edges -> all outputs 0 immediately. After release, a len=1 (7,8) run gives res_data=56.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the dot-product sequencer: state encodings and
// default operand / term-count widths.
package mac_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams operand pairs through an external combinational
// MAC datapath, keeps the running sum locally and returns it on a result handshake.
//
// Handshakes: a transfer happens on a rising CLK edge where valid && ready.
// in_ready/res_valid depend only on the state register; valid never waits on ready.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cfg_start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [2*WIDTH-1:0] cfg_acc_init,
    input  logic               cfg_abort,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   mac_mx,
    output logic [WIDTH-1:0]   mac_my,
    output logic [2*WIDTH-1:0] mac_az,
    input  logic [2*WIDTH-1:0] mac_res,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic [1:0]         dbg_state
);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     r_len;

    state_t               w_state_d;
    logic [2*WIDTH-1:0]   w_acc_d;
    logic [LEN_W-1:0]     w_cnt_d;
    logic [LEN_W-1:0]     w_len_d;
    logic [LEN_W-1:0]     w_cnt_inc;
    logic                 w_run;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
            r_len   <= w_len_d;
        end
    end

    // Abort takes priority over every other event, including a same-cycle accept.
    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        w_len_d   = r_len;
        w_cnt_inc = r_cnt + LEN_W'(1);
        if (cfg_abort) begin
            w_state_d = ST_IDLE;
            w_acc_d   = '0;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        w_len_d   = cfg_len;
                        w_acc_d   = cfg_acc_init;
                        w_cnt_d   = '0;
                        w_state_d = (cfg_len != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        w_acc_d = mac_res;
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    assign w_run     = (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign in_ready  = w_run;
    assign res_valid = (r_state == ST_DONE);
    assign res_data  = res_valid ? r_acc : '0;
    assign mac_mx    = w_run ? in_x : '0;
    assign mac_my    = w_run ? in_y : '0;
    assign mac_az    = r_acc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed vector table, hand-written
// abort/reset sequences and randomized jobs against a dot-product model.
module tb_mac_seq_ctrl;

    localparam int W = 16;
    localparam int L = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          cfg_start;
    logic [L-1:0]  cfg_len;
    logic [2*W-1:0] cfg_acc_init;
    logic          cfg_abort;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic [W-1:0]  mac_mx;
    logic [W-1:0]  mac_my;
    logic [2*W-1:0] mac_az;
    logic [2*W-1:0] mac_res;
    logic          res_valid;
    logic          res_ready;
    logic [2*W-1:0] res_data;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] px[$];
    logic [W-1:0] py[$];

    mac_seq_ctrl #(.WIDTH(W), .LEN_W(L)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_acc_init(cfg_acc_init),
        .cfg_abort(cfg_abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .mac_mx(mac_mx), .mac_my(mac_my), .mac_az(mac_az), .mac_res(mac_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dbg_state(dbg_state)
    );

    // Behavioural stand-in for the shared combinational MAC datapath.
    assign mac_res = mac_az + (32'(mac_mx) * 32'(mac_my));

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_dot(input logic [31:0] init);
        logic [63:0] sum;
        sum = 64'(init);
        foreach (px[k]) sum = sum + 64'(px[k]) * 64'(py[k]);
        return sum[31:0];
    endfunction

    // stall: 0 = continuous valid, 1 = one idle cycle before every beat, 2 = random idles.
    task automatic run_job(input logic [L-1:0] len, input logic [31:0] init, input int stall,
                           input int rr_wait, input logic [31:0] exp, input string name);
        logic [31:0] part;
        int i;
        int guard;
        bit idled;
        part  = init;
        i     = 0;
        guard = 0;
        idled = 0;
        cfg_start = 1; cfg_len = len; cfg_acc_init = init;
        @(negedge CLK);
        cfg_start = 0;
        check({name, " busy_after_start"}, 64'(busy), 64'd1);
        if (len == 0) check({name, " no_in_ready"}, 64'(in_ready), 64'd0);
        while (i < int'(len) && guard < 1000) begin
            guard++;
            check({name, " in_ready"}, 64'(in_ready), 64'd1);
            check({name, " mac_az_partial"}, 64'(mac_az), 64'(part));
            if ((stall == 1 && !idled) || (stall == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 0; idled = 1;
                cfg_start = 1; cfg_len = 8'd1; cfg_acc_init = 32'hDEADBEEF;
                @(negedge CLK);
                cfg_start = 0;
            end else begin
                idled = 0;
                in_valid = 1; in_x = px[i]; in_y = py[i];
                #1;
                check({name, " mac_mx"}, 64'(mac_mx), 64'(px[i]));
                part = part + 32'(px[i]) * 32'(py[i]);
                @(negedge CLK);
                i++;
            end
        end
        in_valid = 0;
        if (i < int'(len)) check({name, " feed_timeout"}, 64'(i), 64'(len));
        check({name, " res_valid"}, 64'(res_valid), 64'd1);
        check({name, " res_data"}, 64'(res_data), 64'(exp));
        check({name, " in_ready_done"}, 64'(in_ready), 64'd0);
        for (int k = 0; k < rr_wait; k++) begin
            cfg_start = 1; cfg_len = 8'd0; cfg_acc_init = 32'hCAFEF00D;
            @(negedge CLK);
            check({name, " res_valid_held"}, 64'(res_valid), 64'd1);
            check({name, " res_data_held"}, 64'(res_data), 64'(exp));
        end
        cfg_start = 0;
        res_ready = 1;
        @(negedge CLK);
        res_ready = 0;
        check({name, " busy_after_ack"}, 64'(busy), 64'd0);
        check({name, " res_valid_after_ack"}, 64'(res_valid), 64'd0);
    endtask

    typedef struct {
        logic [L-1:0]      len;
        logic [31:0]       init;
        logic [3:0][W-1:0] xs;
        logic [3:0][W-1:0] ys;
        int                stall;
        int                rr_wait;
        logic [31:0]       exp;
        string             name;
    } vec_t;

    function automatic vec_t mk(input logic [L-1:0] len, input logic [31:0] init,
                                input logic [W-1:0] x0, input logic [W-1:0] y0,
                                input logic [W-1:0] x1, input logic [W-1:0] y1,
                                input logic [W-1:0] x2, input logic [W-1:0] y2,
                                input logic [W-1:0] x3, input logic [W-1:0] y3,
                                input int stall, input int rr_wait,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.len = len; v.init = init;
        v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
        v.ys[0] = y0; v.ys[1] = y1; v.ys[2] = y2; v.ys[3] = y3;
        v.stall = stall; v.rr_wait = rr_wait; v.exp = exp; v.name = name;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = mk(8'd3, 32'd0, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 32'd68, "basic");
        vecs[1] = mk(8'd1, 32'h0001FFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, "wrap");
        vecs[2] = mk(8'd0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, "zero_len");
        vecs[3] = mk(8'd2, 32'd10, 1, 1, 3, 3, 0, 0, 0, 0, 1, 5, 32'd20, "stall_bp");
        vecs[4] = mk(8'd1, 32'd0, 7, 8, 0, 0, 0, 0, 0, 0, 0, 2, 32'd56, "len1");
        vecs[5] = mk(8'd4, 32'd100, 10, 10, 20, 3, 0, 5, 16'hFFFF, 2, 2, 3, 32'd131330, "len4_mix");

        RST_N = 0; cfg_start = 0; cfg_len = 0; cfg_acc_init = 0; cfg_abort = 0;
        in_valid = 0; in_x = 0; in_y = 0; res_ready = 0;
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset res_data", 64'(res_data), 64'd0);
        check("reset mac_az", 64'(mac_az), 64'd0);
        check("reset mac_mx", 64'(mac_mx), 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            px.delete(); py.delete();
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                px.push_back(vecs[v].xs[k]);
                py.push_back(vecs[v].ys[k]);
            end
            run_job(vecs[v].len, vecs[v].init, vecs[v].stall, vecs[v].rr_wait,
                    vecs[v].exp, vecs[v].name);
        end

        // Abort together with the second beat: that beat is dropped, no result.
        cfg_start = 1; cfg_len = 8'd4; cfg_acc_init = 32'd0;
        @(negedge CLK);
        cfg_start = 0;
        in_valid = 1; in_x = 16'd3; in_y = 16'd4;
        @(negedge CLK);
        check("abort mac_az_beat1", 64'(mac_az), 64'd12);
        in_x = 16'd9; in_y = 16'd9; cfg_abort = 1;
        @(negedge CLK);
        cfg_abort = 0; in_valid = 0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort acc_cleared", 64'(mac_az), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            @(negedge CLK);
            check("abort no_res_valid", 64'(res_valid), 64'd0);
        end
        px = '{16'd5}; py = '{16'd5};
        run_job(8'd1, 32'd0, 0, 0, 32'd25, "after_abort");

        // Abort beats a same-cycle res_ready in DONE, and a same-cycle start in IDLE.
        cfg_start = 1; cfg_len = 8'd0; cfg_acc_init = 32'h55;
        @(negedge CLK);
        cfg_start = 0;
        check("done_abort res_valid_before", 64'(res_valid), 64'd1);
        cfg_abort = 1; res_ready = 1;
        @(negedge CLK);
        res_ready = 0;
        check("done_abort busy", 64'(busy), 64'd0);
        check("done_abort acc_cleared", 64'(mac_az), 64'd0);
        cfg_start = 1; cfg_len = 8'd2;
        @(negedge CLK);
        cfg_start = 0; cfg_abort = 0;
        check("start_abort stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset between clock edges in the middle of a run.
        cfg_start = 1; cfg_len = 8'd3; cfg_acc_init = 32'd77;
        @(negedge CLK);
        cfg_start = 0;
        in_valid = 1; in_x = 16'd11; in_y = 16'd13;
        @(negedge CLK);
        #2 RST_N = 0;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst in_ready", 64'(in_ready), 64'd0);
        check("async_rst res_valid", 64'(res_valid), 64'd0);
        check("async_rst mac_az", 64'(mac_az), 64'd0);
        check("async_rst mac_mx", 64'(mac_mx), 64'd0);
        check("async_rst res_data", 64'(res_data), 64'd0);
        in_valid = 0;
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);
        px = '{16'd7}; py = '{16'd8};
        run_job(8'd1, 32'd0, 0, 0, 32'd56, "after_reset");

        // Randomized jobs checked against the dot-product model.
        for (int j = 0; j < 25; j++) begin
            logic [L-1:0] rlen;
            logic [31:0]  rinit;
            rlen  = L'($urandom_range(0, 7));
            rinit = $urandom();
            px.delete(); py.delete();
            for (int k = 0; k < int'(rlen); k++) begin
                px.push_back(W'($urandom()));
                py.push_back(W'($urandom()));
            end
            run_job(rlen, rinit, 2, $urandom_range(0, 3), model_dot(rinit), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
